// File: rtl/spi_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_mem_arbiter_pkg
// Brief   : Shared defaults and types for the SPI sample-memory arbiter.
//           Default AW/DW match spi_mem_controller and the capture engine.
// Revision: 1.0 - initial release
// ============================================================================
package spi_mem_arbiter_pkg;

  localparam int c_DEF_AW       = 12;
  localparam int c_DEF_DW       = 16;
  localparam int c_DEF_MAX_WAIT = 8;

  // Which requester owns the memory port this cycle
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_WR   = 2'd1,
    ACC_RD   = 2'd2
  } acc_e;

endpackage
`default_nettype wire

// File: rtl/spi_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_mem_arbiter_if
// Brief   : Bundle of capture, SPI-read, RAM and status signals around the
//           arbiter. slave = arbiter side, master = surrounding system.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          cap_req;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          clr_stat;
  logic          cap_stall;

  modport slave (
    input  cap_req, cap_addr, cap_wdata, rd_req, rd_addr, mem_rdata, clr_stat,
    output cap_gnt, rd_gnt, rd_data, rd_valid, mem_addr, mem_wdata, mem_we,
           cap_stall
  );

  modport master (
    output cap_req, cap_addr, cap_wdata, rd_req, rd_addr, mem_rdata, clr_stat,
    input  cap_gnt, rd_gnt, rd_data, rd_valid, mem_addr, mem_wdata, mem_we,
           cap_stall
  );
endinterface
`default_nettype wire

// File: rtl/spi_mem_arbiter_starve_timer.sv
`default_nettype none
// ============================================================================
// Module  : spi_mem_arbiter_starve_timer
// Brief   : Saturating count of cycles a pending SPI read has been denied;
//           raises force_rd once the count reaches MAX_WAIT.
// Revision: 1.0 - initial release
// ============================================================================
module spi_mem_arbiter_starve_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic rd_req,
  input  logic rd_gnt,
  output logic force_rd
);

  localparam int                c_CW  = $clog2(MAX_WAIT + 1);
  localparam logic [c_CW-1:0]   c_MAX = c_CW'(MAX_WAIT);

  logic [c_CW-1:0] r_wait_cnt;

  // Count denied cycles; any grant or a dropped request restarts the wait
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wait_cnt <= '0;
    end else if (!rd_req || rd_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign force_rd = (r_wait_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/spi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_mem_arbiter
// Brief   : Single-port sample RAM arbiter. Capture writes have priority over
//           SPI reads; reads return through a fixed 2-cycle pipeline.
//           Optional starvation guard + sticky stall flag enabled by
//           defining SPI_MEM_ARB_STARVE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int AW       = c_DEF_AW,
  parameter int DW       = c_DEF_DW,
  parameter int MAX_WAIT = c_DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               nrst,
  spi_mem_arbiter_if.slave   bus
);

  acc_e          w_acc;
  logic          w_force;
  logic          w_cap_gnt;
  logic          w_rd_gnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic [1:0]    r_rd_tag;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

`ifdef SPI_MEM_ARB_STARVE_EN
  logic r_cap_stall;

  spi_mem_arbiter_starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_timer (
    .clk      (clk),
    .nrst     (nrst),
    .rd_req   (bus.rd_req),
    .rd_gnt   (w_rd_gnt),
    .force_rd (w_force)
  );

  // Sticky record of any denied capture write; a new denial beats a clear
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cap_stall <= 1'b0;
    end else if (bus.cap_req && !w_cap_gnt) begin
      r_cap_stall <= 1'b1;
    end else if (bus.clr_stat) begin
      r_cap_stall <= 1'b0;
    end
  end

  assign bus.cap_stall = r_cap_stall;
`else
  logic w_unused_cfg;

  assign w_force       = 1'b0;
  assign bus.cap_stall = 1'b0;
  assign w_unused_cfg  = ^{bus.clr_stat, 8'(MAX_WAIT)};
`endif

  // Pick this cycle's owner: capture first unless a starved read is forced
  always_comb begin
    w_acc = ACC_NONE;
    if (nrst) begin
      if (bus.cap_req && !(bus.rd_req && w_force)) begin
        w_acc = ACC_WR;
      end else if (bus.rd_req) begin
        w_acc = ACC_RD;
      end
    end
  end

  assign w_cap_gnt   = (w_acc == ACC_WR);
  assign w_rd_gnt    = (w_acc == ACC_RD);
  assign bus.cap_gnt = w_cap_gnt;
  assign bus.rd_gnt  = w_rd_gnt;

  // Register the RAM command; address/data hold when not refreshed
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_we <= w_cap_gnt;
      if (w_cap_gnt) begin
        r_mem_addr  <= bus.cap_addr;
        r_mem_wdata <= bus.cap_wdata;
      end else if (w_rd_gnt) begin
        r_mem_addr  <= bus.rd_addr;
      end
    end
  end

  // Read tag tracks the access alongside the RAM latency, then captures data
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rd_tag   <= 2'b00;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_tag   <= {r_rd_tag[0], w_rd_gnt};
      r_rd_valid <= r_rd_tag[1];
      if (r_rd_tag[1]) begin
        r_rd_data <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;

endmodule
`default_nettype wire
